// File: rtl/dpwm_pkg.sv
// Shared types and default sizing for the dead-time DPWM.
package dpwm_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_DT_RISE = 3'd1,
    ST_HS_ON   = 3'd2,
    ST_DT_FALL = 3'd3,
    ST_LS_ON   = 3'd4
  } dt_state_t;

  localparam int unsigned N_BITS_DEF    = 6;
  localparam int unsigned DT_CYCLES_DEF = 2;

endpackage

// File: rtl/deadtime_gen.sv
// Dead-time FSM: turns the raw PWM compare into non-overlapping high/low-side drives.
module deadtime_gen
  import dpwm_pkg::*;
#(
  parameter int unsigned DT_CYCLES = DT_CYCLES_DEF,
  parameter int unsigned DT_W      = N_BITS_DEF
) (
  input  logic clk_in,
  input  logic rst,
  input  logic i_enable,
  input  logic i_raw,
  output logic o_hs,
  output logic o_ls
);

  localparam logic [DT_W-1:0] DT_LAST = DT_W'(DT_CYCLES);
  localparam logic [DT_W-1:0] DT_ONE  = DT_W'(1);

  dt_state_t       r_state;
  logic [DT_W-1:0] r_dt_cnt;
  logic            r_hs;
  logic            r_ls;

  // Outputs are registered together with each state change, so they always decode r_state.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state  <= ST_OFF;
      r_dt_cnt <= '0;
      r_hs     <= 1'b0;
      r_ls     <= 1'b0;
    end else if (!i_enable) begin
      r_state <= ST_OFF;
      r_hs    <= 1'b0;
      r_ls    <= 1'b0;
    end else begin
      case (r_state)
        ST_OFF: begin
          r_state  <= i_raw ? ST_DT_RISE : ST_DT_FALL;
          r_dt_cnt <= DT_ONE;
          r_hs     <= 1'b0;
          r_ls     <= 1'b0;
        end
        ST_DT_RISE: begin
          if (!i_raw) begin
            r_state  <= ST_DT_FALL;
            r_dt_cnt <= DT_ONE;
          end else if (r_dt_cnt == DT_LAST) begin
            r_state <= ST_HS_ON;
            r_hs    <= 1'b1;
          end else begin
            r_dt_cnt <= r_dt_cnt + DT_ONE;
          end
        end
        ST_HS_ON: begin
          if (!i_raw) begin
            r_state  <= ST_DT_FALL;
            r_dt_cnt <= DT_ONE;
            r_hs     <= 1'b0;
          end
        end
        ST_DT_FALL: begin
          if (i_raw) begin
            r_state  <= ST_DT_RISE;
            r_dt_cnt <= DT_ONE;
          end else if (r_dt_cnt == DT_LAST) begin
            r_state <= ST_LS_ON;
            r_ls    <= 1'b1;
          end else begin
            r_dt_cnt <= r_dt_cnt + DT_ONE;
          end
        end
        ST_LS_ON: begin
          if (i_raw) begin
            r_state  <= ST_DT_RISE;
            r_dt_cnt <= DT_ONE;
            r_ls     <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_OFF;
          r_hs    <= 1'b0;
          r_ls    <= 1'b0;
        end
      endcase
    end
  end

  assign o_hs = r_hs;
  assign o_ls = r_ls;

endmodule

// File: rtl/dpwm_deadtime.sv
// Counter-based DPWM with shadowed duty word, period strobe and dead-time gate drives.
module dpwm_deadtime
  import dpwm_pkg::*;
#(
  parameter int unsigned N_BITS    = N_BITS_DEF,
  parameter int unsigned DT_CYCLES = DT_CYCLES_DEF
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_BITS-1:0] duty_in,
  output logic              pwm_hs,
  output logic              pwm_ls,
  output logic              period_tick,
  output logic [N_BITS-1:0] duty_latched
);

  if (DT_CYCLES < 1 || DT_CYCLES > (2 ** N_BITS) - 2) begin : g_dt_range
    $error("DT_CYCLES out of range 1..2**N_BITS-2");
  end

  localparam logic [N_BITS-1:0] CNT_ONE = N_BITS'(1);

  logic [N_BITS-1:0] r_cnt;
  logic [N_BITS-1:0] r_duty;
  logic              r_tick;
  logic              w_cnt_max;
  logic              w_raw;

  assign w_cnt_max = (r_cnt == '1);
  assign w_raw     = (r_cnt < r_duty);

  // Shadow load on the all-ones count, so a new duty word only lands at a period boundary.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt  <= '1;
      r_duty <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= enable ? r_cnt + CNT_ONE : '1;
      r_tick <= enable & w_cnt_max;
      if (w_cnt_max) begin
        r_duty <= duty_in;
      end
    end
  end

  deadtime_gen #(
    .DT_CYCLES(DT_CYCLES),
    .DT_W     (N_BITS)
  ) u_deadtime_gen (
    .clk_in  (clk_in),
    .rst     (rst),
    .i_enable(enable),
    .i_raw   (w_raw),
    .o_hs    (pwm_hs),
    .o_ls    (pwm_ls)
  );

  assign period_tick  = r_tick;
  assign duty_latched = r_duty;

endmodule
